// File: rtl/pipe_memory_skid.sv
// pipe_memory_skid: elastic MEM->WB register with a two-entry skid buffer, flush, x0-write suppression and saturating stall counter
module pipe_memory_skid #(
    parameter int DATA_WIDTH  = 32,
    parameter int WRITE_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   validm,
    output logic                   readym,
    input  logic [DATA_WIDTH-1:0]  aluresultm,
    input  logic [DATA_WIDTH-1:0]  readdatam,
    input  logic [DATA_WIDTH-1:0]  pcplus4m,
    input  logic [WRITE_WIDTH-1:0] rdm,
    input  logic                   regwritem,
    input  logic [1:0]             resultsrcm,
    output logic                   validw,
    input  logic                   readyw,
    output logic [DATA_WIDTH-1:0]  aluresultw,
    output logic [DATA_WIDTH-1:0]  readdataw,
    output logic [DATA_WIDTH-1:0]  pcplus4w,
    output logic [WRITE_WIDTH-1:0] rdw,
    output logic                   regwritew,
    output logic [1:0]             resultsrcw,
    output logic [CNT_WIDTH-1:0]   stallcnt
);
    typedef struct packed {
        logic                   regwrite;
        logic [1:0]             resultsrc;
        logic [DATA_WIDTH-1:0]  aluresult;
        logic [DATA_WIDTH-1:0]  readdata;
        logic [WRITE_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]  pcplus4;
    } payload_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t   state, state_d;
    payload_t main_q, skid_q, p;
    logic     accept, emit, load_main, load_skid, shift;
    assign p      = {regwritem, resultsrcm, aluresultm, readdatam, rdm, pcplus4m};
    assign readym = state != TWO;
    assign validw = state != EMPTY;
    assign accept = validm && readym;
    assign emit   = validw && readyw;
    always_comb begin
        state_d   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        case (state)
            EMPTY: begin
                state_d   = accept ? ONE : EMPTY;
                load_main = accept;
            end
            ONE: begin
                state_d   = accept ? (emit ? ONE : TWO) : (emit ? EMPTY : ONE);
                load_main = accept && emit;
                load_skid = accept && !emit;
            end
            TWO: begin
                state_d = emit ? ONE : TWO;
                shift   = emit;
            end
            default: state_d = EMPTY;
        endcase
        // flush overrides everything; an accept in this cycle is silently dropped
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            shift     = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= EMPTY;
        else        state <= state_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)  main_q <= p;
            else if (shift) main_q <= skid_q;
            if (load_skid)  skid_q <= p;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                                        stallcnt <= '0;
        else if (validw && !readyw && stallcnt != '1)      stallcnt <= stallcnt + CNT_WIDTH'(1);
    assign aluresultw = main_q.aluresult;
    assign readdataw  = main_q.readdata;
    assign pcplus4w   = main_q.pcplus4;
    assign rdw        = main_q.rd;
    assign resultsrcw = main_q.resultsrc;
    assign regwritew  = main_q.regwrite && validw && (main_q.rd != '0);
endmodule

// File: tb/tb_pipe_memory_skid.sv
// tb_pipe_memory_skid: random and directed stimulus scored against a depth-2 FIFO reference model
module tb_pipe_memory_skid;
    localparam int DW = 32;
    localparam int WW = 5;
    localparam int CW = 4;
    logic          clk = 0, rst_n = 0, flush = 0, validm = 0, readyw = 0;
    logic          readym, validw, regwritew, regwritem = 0;
    logic [DW-1:0] aluresultm = 0, readdatam = 0, pcplus4m = 0;
    logic [DW-1:0] aluresultw, readdataw, pcplus4w;
    logic [WW-1:0] rdm = 0, rdw;
    logic [1:0]    resultsrcm = 0, resultsrcw;
    logic [CW-1:0] stallcnt;
    typedef struct {
        logic          rw;
        logic [1:0]    rs;
        logic [DW-1:0] alu, rdat, pc;
        logic [WW-1:0] rd;
    } instr_t;
    instr_t q[$];
    int  cnt_m = 0;
    int  errors = 0, checks = 0;
    bit  acc, emt;
    pipe_memory_skid #(.DATA_WIDTH(DW), .WRITE_WIDTH(WW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .validm(validm), .readym(readym),
        .aluresultm(aluresultm), .readdatam(readdatam), .pcplus4m(pcplus4m), .rdm(rdm),
        .regwritem(regwritem), .resultsrcm(resultsrcm), .validw(validw), .readyw(readyw),
        .aluresultw(aluresultw), .readdataw(readdataw), .pcplus4w(pcplus4w), .rdw(rdw),
        .regwritew(regwritew), .resultsrcw(resultsrcw), .stallcnt(stallcnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic drive(input bit v, input logic [WW-1:0] rd, input logic [DW-1:0] alu,
                         input bit rw, input bit rdy, input bit fl);
        validm     = v;
        rdm        = rd;
        aluresultm = alu;
        regwritem  = rw;
        readyw     = rdy;
        flush      = fl;
        readdatam  = $urandom;
        pcplus4m   = $urandom;
        resultsrcm = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_validw"}, 64'(validw), 64'(0));
        chk({tag, "_regwritew"}, 64'(regwritew), 64'(0));
        chk({tag, "_readym"}, 64'(readym), 64'(1));
        chk({tag, "_aluresultw"}, 64'(aluresultw), 64'(0));
        chk({tag, "_readdataw"}, 64'(readdataw), 64'(0));
        chk({tag, "_pcplus4w"}, 64'(pcplus4w), 64'(0));
        chk({tag, "_rdw"}, 64'(rdw), 64'(0));
        chk({tag, "_resultsrcw"}, 64'(resultsrcw), 64'(0));
        chk({tag, "_stallcnt"}, 64'(stallcnt), 64'(0));
    endtask
    // Reference: a two-deep FIFO; readym means "room left", validw means "not empty"
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
        end else begin
            chk("validw", 64'(validw), 64'(q.size() != 0));
            chk("readym", 64'(readym), 64'(q.size() < 2));
            chk("stallcnt", 64'(stallcnt), 64'(cnt_m));
            if (q.size() != 0) begin
                chk("aluresultw", 64'(aluresultw), 64'(q[0].alu));
                chk("readdataw", 64'(readdataw), 64'(q[0].rdat));
                chk("pcplus4w", 64'(pcplus4w), 64'(q[0].pc));
                chk("rdw", 64'(rdw), 64'(q[0].rd));
                chk("resultsrcw", 64'(resultsrcw), 64'(q[0].rs));
                chk("regwritew", 64'(regwritew), 64'(q[0].rw && q[0].rd != 0));
            end else
                chk("regwritew_idle", 64'(regwritew), 64'(0));
            acc = validm && q.size() < 2;
            emt = q.size() != 0 && readyw;
            if (q.size() != 0 && !readyw && cnt_m < (1 << CW) - 1) cnt_m++;
            if (emt) void'(q.pop_front());
            if (acc) q.push_back('{rw: regwritem, rs: resultsrcm, alu: aluresultm,
                                   rdat: readdatam, pc: pcplus4m, rd: rdm});
            if (flush) q.delete();
        end
    end
    initial begin
        #3;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 1; i <= 8; i++) drive(1, WW'(i), DW'(32'h100 + i), 1, 1, 0);
        repeat (2) drive(0, 0, 0, 0, 1, 0);
        drive(1, 9, 32'h200, 1, 1, 0);
        for (int k = 0; k < 3; k++) drive(1, WW'(10 + k), DW'(32'h210 + k), 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, WW'(20 + k), DW'(32'h220 + k), 1, 1, 0);
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        chk("bp_stallcnt", 64'(stallcnt), 64'(3));
        drive(1, 0, 32'hDEADBEEF, 1, 1, 0);
        chk("x0_validw", 64'(validw), 64'(1));
        chk("x0_rdw", 64'(rdw), 64'(0));
        chk("x0_regwritew", 64'(regwritew), 64'(0));
        chk("x0_aluresultw", 64'(aluresultw), 64'(32'hDEADBEEF));
        drive(1, 5, 32'hDEADBEEF, 1, 1, 0);
        chk("x5_rdw", 64'(rdw), 64'(5));
        chk("x5_regwritew", 64'(regwritew), 64'(1));
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 11, 32'h311, 1, 0, 0);
        drive(1, 12, 32'h312, 1, 0, 0);
        chk("two_readym", 64'(readym), 64'(0));
        drive(1, 13, 32'h313, 1, 0, 1);
        chk("flush_validw", 64'(validw), 64'(0));
        chk("flush_regwritew", 64'(regwritew), 64'(0));
        chk("flush_readym", 64'(readym), 64'(1));
        for (int k = 0; k < 3; k++) drive(1, WW'(14 + k), DW'(32'h314 + k), 1, 1, 0);
        repeat (2) drive(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 400; k++)
            drive($urandom_range(0, 1) == 1, WW'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        rst_n = 0;
        drive(0, 0, 0, 0, 1, 0);
        rst_n = 1;
        drive(1, 7, 32'h701, 1, 0, 0);
        drive(1, 8, 32'h702, 1, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0, 0);
        chk("stall7_stallcnt", 64'(stallcnt), 64'(7));
        chk("stall7_readym", 64'(readym), 64'(0));
        chk("stall7_validw", 64'(validw), 64'(1));
        #2;
        rst_n = 0;
        #1;
        chk_zero("async");
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1;
        drive(1, 3, 32'h900, 1, 0, 0);
        repeat (20) drive(0, 0, 0, 0, 0, 0);
        chk("sat_stallcnt", 64'(stallcnt), 64'(15));
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_memory_skid.md
# pipe_memory_skid

Elastic MEM→WB pipeline register for the RV32I core. It replaces the free-running memory/writeback latch with a valid/ready handshake, so variable-latency data memory and a stalling writeback stage can back-pressure each other without losing instructions. It sits between the memory stage and the writeback/result mux. It adds synchronous flush, x0-write suppression and a saturating back-pressure counter for performance analysis.

## Interface
- DATA_WIDTH, 32, width of aluresult/readdata/pcplus4 payload
- WRITE_WIDTH, 5, destination register index width
- CNT_WIDTH, 16, width of stall counter

- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- validm  in  1  memory stage presents an instruction
- readym  out  1  block can accept this cycle
- aluresultm, readdatam, pcplus4m  in  DATA_WIDTH  memory-stage payload
- rdm  in  WRITE_WIDTH  destination register
- regwritem  in  1  register-write control
- resultsrcm  in  2  result-select control
- validw  out  1  writeback payload valid
- readyw  in  1  writeback stage consumes this cycle
- aluresultw, readdataw, pcplus4w  out  DATA_WIDTH  registered payload
- rdw  out  WRITE_WIDTH  registered destination
- regwritew  out  1  write-enable, gated by validw and rdw≠0
- resultsrcw  out  2  registered result-select
- stallcnt  out  CNT_WIDTH  cycles with validw=1 and readyw=0, saturating

## Operation
- Payload bundle P = {regwritem, resultsrcm, aluresultm, readdatam, rdm, pcplus4m}. The block holds two P registers: main (drives outputs) and skid.
- Accept event: validm && readym. Emit event: validw && readyw.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - TWO: main and skid valid.
- EMPTY:
  - accept → ONE, main←P.
- ONE:
  - accept && !emit → TWO, skid←P.
  - !accept && emit → EMPTY.
  - accept && emit → ONE, main←P.
  - neither → hold.
- TWO:
  - emit → ONE, main←skid.
  - otherwise hold. No accept is possible because readym=0.
- readym is registered: 1 in EMPTY/ONE, 0 in TWO. It is a pure function of the state register and has no combinational path from readyw.
- validw = (state ≠ EMPTY).
- regwritew = main.regwrite && validw && (rdw ≠ 0). Writes to x0 never reach the register file.
- Output payload is held stable while validw && !readyw.
- flush has the highest priority:
  - Next state is EMPTY, so validw=0 and regwritew=0 the next cycle.
  - An accept in the flush cycle completes toward upstream but the instruction is discarded.
  - Payload registers need not be cleared.
- stallcnt increments when validw && !readyw and saturates at all-ones. It is cleared only by reset; flush does not affect it.

## Timing
- Reset (async assert, synchronous-safe release):
  - State EMPTY, readym=1, validw=0, regwritew=0.
  - All payload outputs 0, stallcnt=0.
- Latency: accept at edge N gives validw=1 after edge N. Single-cycle latency when EMPTY, or when in ONE with a simultaneous emit.
- Throughput: one instruction per cycle with readyw held high. No bubbles are inserted.
- Back-pressure: readyw dropped for k cycles under continuous validm.
  - At most one extra instruction is absorbed (into skid), then readym=0.
  - Ordering is preserved: skid is emitted immediately after main.
- Reset mid-operation: state and outputs return to reset values immediately (asynchronous). Held instructions are lost.
- Flush while in TWO: both entries are dropped, readym=1 the next cycle.

## Test plan
- Streaming: readyw=1, 8 instructions back-to-back, rd=1..8, aluresult=0x100+i.
  - Required: outputs appear 1 cycle later in order, validw continuous, stallcnt=0.
- Back-pressure: readyw=0 for 3 cycles during a stream.
  - Required: readym falls 1 cycle after the second instruction is held.
  - Required: no instruction is lost or duplicated, stallcnt=3, order intact on release.
- x0 suppression: regwritem=1, rdm=0, aluresult=0xDEADBEEF.
  - Required: validw=1, rdw=0, regwritew=0.
  - Same instruction with rdm=5: regwritew=1.
- Flush in TWO with a simultaneous new validm.
  - Required: next cycle validw=0, regwritew=0, readym=1.
  - Required: the flushed and incoming instructions never appear.
- Async reset asserted mid-stall (state TWO, stallcnt=7).
  - Required: validw=0, all outputs 0 and stallcnt=0 without waiting for a clock edge; readym=1.
- Saturation: CNT_WIDTH=4, hold readyw=0 for 20 cycles.
  - Required: stallcnt stops at 15.
